seq_divider: RTL
================

Name: seq_divider

Overview:
- N-bit unsigned binary sequential restoring divider; the inverse companion to the sequential shift-add multiplier.
- Splits a 2N-bit dividend (e.g. a multiplier AQ product) by an N-bit divisor into an N-bit quotient and an N-bit remainder.
- Takes one shift/trial-subtract iteration per clock.
- Uses the same start/ready handshake as the multiplier, so both blocks share benches and control sequencing.

Parameters:
N, 8, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
clock  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
start  input  1  level request; operation accepted when high in IDLE
AQin  input  2N  dividend, sampled on the accepting edge only
Min  input  N  divisor, sampled on the accepting edge only
ready  output  1  high when idle or result valid; low while busy
Q  output  N  quotient
R  output  N  remainder
div_zero  output  1  result flag: divisor was 0
overflow  output  1  result flag: quotient does not fit in N bits

Behaviour:
- Reset is asynchronous and active-low. When n_rst=0: state=IDLE, ready=1, Q=0, R=0, div_zero=0, overflow=0, internal A/Q/M/count all cleared.
- States:
  - IDLE (ready=1).
  - BUSY (ready=0).
  - DONE (ready=1).
- IDLE, start=1 at edge k:
  - Capture Min→M, AQin[2N-1:N]→A, AQin[N-1:0]→Qreg, count=N.
  - Clear div_zero and overflow.
  - If Min==0: div_zero=1, Q=0, R=0, go to DONE; ready stays 1 with a one-cycle low pulse, i.e. ready=0 for the cycle after edge k and 1 from edge k+1.
  - Else if AQin[2N-1:N] >= Min: overflow=1, Q=0, R=0; same one-cycle ready pulse; go to DONE.
  - Else go to BUSY; ready=0 from edge k.
- BUSY, each edge (exactly N edges, k+1..k+N):
  - {A,Qreg} shifted left 1 into an (N+1)-bit A.
  - Trial diff = A - M.
  - If diff is non-negative: A=diff[N-1:0], Qreg[0]=1. Otherwise restore A, Qreg[0]=0.
  - count decrements.
  - On the edge where count reaches 0: Q=Qreg result, R=A, state=DONE, ready=1.
  - Total latency: ready rises at edge k+N after the accepting edge k; a positive ready edge marks a valid result.
- Q/R/flags are updated only at completion or at an error decision. They hold stable through DONE and IDLE until the next accepted start.
- DONE: stays while start=1, so a held start never retriggers. Goes to IDLE on the first edge with start=0.
- start, AQin and Min are ignored while BUSY; operands are latched and input changes have no effect.
- Invariant for every non-error result: Q*Min + R == AQin and R < Min.
- Reset asserted mid-BUSY aborts immediately to the reset values above; the next operation needs a fresh start after n_rst releases.
- All arithmetic is unsigned. A is N+1 bits internally to hold the shifted-out MSB, so no trial-subtract wraps.

Test Plan:
- N=8, AQin=15, Min=3, start held high -> ready falls, then rises exactly 8 clocks after the accepting edge; Q=5, R=0, flags 0; no retrigger while start stays high.
- AQin=200, Min=7 -> Q=28, R=4; then start=0 then 1 with AQin=65025, Min=255 -> Q=255, R=0 (full-width round trip of the multiplier's max product).
- AQin=0x0A00, Min=10 -> overflow=1, Q=0, R=0, ready high one cycle after the accepting edge; div_zero=0.
- AQin=1234, Min=0 -> div_zero=1, overflow=0, Q=0, R=0, ready high one cycle after the accepting edge.
- Start AQin=1000, Min=10, change AQin/Min every cycle while BUSY -> Q=100, R=0 (inputs latched).
- Pulse n_rst low 3 clocks into BUSY -> ready=1, Q=R=0, flags 0 immediately (asynchronous); a subsequent start with AQin=99, Min=9 -> Q=11, R=0.

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/ready handshake and operand/result bus of the sequential restoring divider.
// It uses the same handshake as the shift-add multiplier, so the control logic driving either block is the same.
interface seq_divider_if #(
  parameter int N = 8
);
  logic             start;
  logic [2*N-1:0]   AQin;
  logic [N-1:0]     Min;
  logic             ready;
  logic [N-1:0]     Q;
  logic [N-1:0]     R;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, AQin, Min,
    input  ready, Q, R, div_zero, overflow
  );

  modport slave (
    input  start, AQin, Min,
    output ready, Q, R, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// N-bit unsigned sequential restoring divider: divides a 2N-bit dividend by an N-bit divisor.
// It does one shift/trial-subtract per clock, and the quotient, remainder and flags are registered.
module seq_divider #(
  parameter int N = 8
) (
  input  logic        clock,
  input  logic        n_rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(N);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [N:0]    a;
  logic [N-1:0]  qreg;
  logic [N-1:0]  m;
  logic [CW-1:0] count;

  logic [N:0]    shifted;
  logic [N+1:0]  trial;
  logic          fits;
  logic [N:0]    a_next;
  logic [N-1:0]  q_next;

  // The extra top bit of trial acts as a borrow flag, so the subtraction never wraps.
  always_comb begin
    // NOTE: every combinational output is assigned on every path; otherwise a latch would be inferred.
    shifted = {a[N-1:0], qreg[N-1]};
    trial   = {1'b0, shifted} - {2'b00, m};
    fits    = ~trial[N+1];
    a_next  = fits ? trial[N:0] : shifted;
    q_next  = {qreg[N-2:0], fits};
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      a            <= '0;
      qreg         <= '0;
      m            <= '0;
      count        <= '0;
      bus.ready    <= 1'b1;
      bus.Q        <= '0;
      bus.R        <= '0;
      bus.div_zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every branch sees the values from before the edge.
      case (state)
        IDLE: begin
          if (bus.start) begin
            m            <= bus.Min;
            a            <= {1'b0, bus.AQin[2*N-1:N]};
            qreg         <= bus.AQin[N-1:0];
            count        <= COUNT_INIT;
            bus.div_zero <= 1'b0;
            bus.overflow <= 1'b0;
            bus.ready    <= 1'b0;
            if (bus.Min == '0) begin
              bus.div_zero <= 1'b1;
              bus.Q        <= '0;
              bus.R        <= '0;
              state        <= DONE;
            end else if (bus.AQin[2*N-1:N] >= bus.Min) begin
              // The quotient only fits in N bits when the upper half of the dividend is smaller than the divisor.
              bus.overflow <= 1'b1;
              bus.Q        <= '0;
              bus.R        <= '0;
              state        <= DONE;
            end else begin
              state <= BUSY;
            end
          end else begin
            bus.ready <= 1'b1;
          end
        end

        BUSY: begin
          a     <= a_next;
          qreg  <= q_next;
          count <= count - 1'b1;
          if (count == COUNT_LAST) begin
            bus.Q     <= q_next;
            bus.R     <= a_next[N-1:0];
            bus.ready <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // If start is still high, the block waits here, so a start held high does not begin a second division.
          bus.ready <= 1'b1;
          if (!bus.start) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
